// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared types and helpers for the logic-gate sweep sequencer.
//   state_e      - sequencer FSM states
//   LED_E..LED_H - bit positions of each gate result on the LED bus
//   VEC_LAST     - final input vector of a sweep
//   expected()   - reference {h,g,f,e} for a given {a,b,c}
package logic_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned LED_W   = 4;
    localparam int unsigned ERR_W   = 8;

    localparam int unsigned LED_E   = 0;
    localparam int unsigned LED_F   = 1;
    localparam int unsigned LED_G   = 2;
    localparam int unsigned LED_H   = 3;

    localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

    // Reference results of the gate datapath: e=a&b, f=~b, g=a|c, h=b^c.
    function automatic logic [LED_W-1:0] expected(input logic a, input logic b, input logic c);
        logic [LED_W-1:0] r;
        r        = '0;
        r[LED_E] = a & b;
        r[LED_F] = ~b;
        r[LED_G] = a | c;
        r[LED_H] = b ^ c;
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_seq_hold_timer.sv
// hold_timer: loadable down-counter for the per-vector dwell.
//   clk_i    - clock (rising edge)
//   load_i   - load value_i into the counter this cycle
//   value_i  - load value (dwell length minus one)
//   expire_o - registered, high while the counter is at zero
// The counter counts down every cycle it is not loaded and parks at zero.
// It carries no reset: it is always loaded before its expiry is consulted.
module hold_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q;

    // Next count: load wins, otherwise decrement down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q    <= cnt_d;
        expire_q <= (cnt_d == '0);
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/logic_gate_seq.sv
// logic_gate_seq: walks {a,b,c} through all eight vectors, captures the gate
// datapath results one cycle after driving each vector, and holds them on the
// LEDs for HOLD_CYC cycles.
//   sys_clk, sys_rst_n          - clock, synchronous active-low reset
//   start, stop, loop_en        - sweep control
//   port_a/b/c                  - registered drive to the datapath
//   rslt_e/f/g/h                - datapath results
//   led, vec_idx, busy, done    - status
//   err, err_cnt                - self-check result
// Build option: LOGIC_GATE_CHK_EN compiles in the result self-check; without
// it err/err_cnt are constant zero.
module logic_gate_seq
    import logic_gate_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 50_000_000,
    parameter int unsigned CNT_W    = $clog2(HOLD_CYC + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              port_a,
    output logic              port_b,
    output logic              port_c,
    input  logic              rslt_e,
    input  logic              rslt_f,
    input  logic              rslt_g,
    input  logic              rslt_h,
    output logic [LED_W-1:0]  led,
    output logic [VEC_W-1:0]  vec_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic               tmr_load_c;
    logic               tmr_expire;
    logic [LED_W-1:0]   rslt_c;
    logic               start_acc_c;
    logic               sample_c;

    always_comb begin
        rslt_c        = '0;
        rslt_c[LED_E] = rslt_e;
        rslt_c[LED_F] = rslt_f;
        rslt_c[LED_G] = rslt_g;
        rslt_c[LED_H] = rslt_h;
    end

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk_i    (sys_clk),
        .load_i   (tmr_load_c),
        .value_i  (CNT_W'(HOLD_CYC - 1)),
        .expire_o (tmr_expire)
    );

    // Sweep FSM: next state and next values of the datapath-facing registers.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        led_d       = led_q;
        done_d      = 1'b0;
        tmr_load_c  = 1'b0;
        start_acc_c = 1'b0;
        sample_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    start_acc_c = 1'b1;
                    vec_d       = '0;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample_c   = 1'b1;
                led_d      = rslt_c;
                tmr_load_c = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_expire) begin
                    if (vec_q != VEC_LAST) begin
                        vec_d   = vec_q + VEC_W'(1);
                        state_d = ST_DRIVE;
                    end else if (loop_en) begin
                        vec_d   = '0;
                        state_d = ST_DRIVE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything except the error record.
        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            vec_d    = '0;
            led_d    = '0;
            done_d   = 1'b0;
            sample_c = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            led_q   <= led_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
        end
    end

`ifdef LOGIC_GATE_CHK_EN
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Compare captured results against the reference; count saturates.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (start_acc_c) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (sample_c && (rslt_c != expected(vec_q[2], vec_q[1], vec_q[0]))) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_chk;
    assign unused_chk = start_acc_c ^ sample_c;
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

    assign port_a  = vec_q[2];
    assign port_b  = vec_q[1];
    assign port_c  = vec_q[0];
    assign vec_idx = vec_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_logic_gate_seq.sv
// Bench for logic_gate_seq with HOLD_CYC=4 (6 cycles per vector). A monitor
// pushes the expected LED value whenever a new vector appears on the ports and
// compares it two cycles later; directed sequences cover timing, loop, stop,
// reset and the optional self-check.
module tb_logic_gate_seq;

    localparam int unsigned HOLD = 4;
    localparam int unsigned PER  = HOLD + 2;
`ifdef LOGIC_GATE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic       loop_en   = 1'b0;
    logic       fault_f   = 1'b0;
    logic       port_a, port_b, port_c;
    logic       rslt_e, rslt_f, rslt_g, rslt_h;
    logic [3:0] led;
    logic [2:0] vec_idx;
    logic       busy, done, err;
    logic [7:0] err_cnt;

    always #5 sys_clk = ~sys_clk;

    // Gate datapath model, with an optional stuck-at-0 on f.
    assign rslt_e = port_a & port_b;
    assign rslt_f = fault_f ? 1'b0 : ~port_b;
    assign rslt_g = port_a | port_c;
    assign rslt_h = port_b ^ port_c;

    logic_gate_seq #(.HOLD_CYC(HOLD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .port_a    (port_a),
        .port_b    (port_b),
        .port_c    (port_c),
        .rslt_e    (rslt_e),
        .rslt_f    (rslt_f),
        .rslt_g    (rslt_g),
        .rslt_h    (rslt_h),
        .led       (led),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_led(input logic [2:0] v, input logic f_stuck);
        logic a, b, c;
        {a, b, c} = v;
        return {b ^ c, a | c, (f_stuck ? 1'b0 : ~b), a & b};
    endfunction

    typedef struct {
        int         due;
        logic [3:0] led;
    } sb_t;

    sb_t        sb_q[$];
    int         cyc          = 0;
    int         n_vec        = 0;
    int         n_done       = 0;
    int         last_vec_cyc = -1;
    logic [2:0] exp_vec      = '0;
    logic       busy_prev    = 1'b0;
    logic [2:0] vec_prev     = '0;

    // Scoreboard monitor: push on each new vector, pop when led is due.
    always @(negedge sys_clk) begin
        sb_t e;
        cyc++;
        if (done) n_done++;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check("led", 32'(led), 32'(e.led));
        end
        if (busy && (!busy_prev || vec_idx != vec_prev)) begin
            if (!busy_prev) exp_vec = '0;
            else if (last_vec_cyc >= 0) check("vec_period", 32'(cyc - last_vec_cyc), PER);
            check("vec_idx", 32'(vec_idx), 32'(exp_vec));
            sb_q.push_back('{cyc + 2, ref_led(exp_vec, fault_f)});
            exp_vec      = exp_vec + 3'd1;
            n_vec++;
            last_vec_cyc = cyc;
        end
        if (!busy) begin
            sb_q.delete();
            last_vec_cyc = -1;
        end
        busy_prev = busy;
        vec_prev  = vec_idx;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Waits for done; optionally pokes start at cycle 'poke'. lat counts
    // cycles from the negedge right after the accepting edge.
    task automatic wait_done(input string tag, input int limit, input int poke, output int lat);
        lat = 0;
        while (lat < limit && !done) begin
            start = (lat == poke);
            @(negedge sys_clk);
            lat++;
        end
        start = 1'b0;
        if (!done) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int lat, vbase, dbase, d_mid;

        // Reset state
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_led", 32'(led), 0);
        check("rst_vec", 32'(vec_idx), 0);
        check("rst_ports", 32'({port_a, port_b, port_c}), 0);
        check("rst_err", 32'({err, err_cnt}), 0);

        // Single sweep, with an ignored start while busy
        dbase = n_done;
        vbase = n_vec;
        pulse_start();
        check("busy_rise", 32'(busy), 1);
        check("first_vec", 32'(vec_idx), 0);
        wait_done("done_timeout1", 200, 10, lat);
        check("done_latency", 32'(lat), 8 * PER);
        check("busy_at_done", 32'(busy), 0);
        @(negedge sys_clk);
        check("done_one_cycle", 32'(done), 0);
        check("led_hold_last", 32'(led), 32'(ref_led(3'd7, 1'b0)));
        check("sweep_vecs", 32'(n_vec - vbase), 8);
        check("sweep_dones", 32'(n_done - dbase), 1);

        // Looping sweep: 20 vectors, then release loop_en
        loop_en = 1'b1;
        dbase   = n_done;
        vbase   = n_vec;
        pulse_start();
        lat = 0;
        while ((n_vec - vbase) < 20 && lat < 400) begin
            @(negedge sys_clk);
            lat++;
        end
        check("loop_reach20", 32'(n_vec - vbase >= 20), 1);
        d_mid   = n_done;
        loop_en = 1'b0;
        wait_done("done_timeout2", 200, -1, lat);
        @(negedge sys_clk);
        check("loop_no_done", 32'(d_mid - dbase), 0);
        check("loop_vecs", 32'(n_vec - vbase), 24);
        check("loop_dones", 32'(n_done - dbase), 1);

        // Stop in HOLD of vector 3, then restart one cycle later
        dbase = n_done;
        pulse_start();
        lat = 0;
        while (vec_idx != 3'd3 && lat < 100) begin
            @(negedge sys_clk);
            lat++;
        end
        check("reach_vec3", 32'(vec_idx), 3);
        repeat (2) @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_ports", 32'({port_a, port_b, port_c}), 0);
        check("stop_led", 32'(led), 0);
        check("stop_done", 32'(done), 0);
        pulse_start();
        check("restart_busy", 32'(busy), 1);
        check("restart_vec", 32'(vec_idx), 0);
        wait_done("done_timeout3", 200, -1, lat);
        check("restart_latency", 32'(lat), 8 * PER);
        @(negedge sys_clk);
        check("stop_dones", 32'(n_done - dbase), 1);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", 32'(busy), 0);
        @(negedge sys_clk);
        check("startstop_busy2", 32'(busy), 0);

        // Self-check with f stuck at 0, then a clean sweep clears it
        fault_f = 1'b1;
        pulse_start();
        check("err_pre_sample", 32'(err), 0);
        repeat (2) @(negedge sys_clk);
        check("err_after_v0", 32'(err), 32'(CHK));
        wait_done("done_timeout4", 200, -1, lat);
        check("err_cnt_done", 32'(err_cnt), CHK ? 4 : 0);
        check("err_at_done", 32'(err), 32'(CHK));
        @(negedge sys_clk);
        fault_f = 1'b0;
        pulse_start();
        check("err_cleared", 32'(err), 0);
        check("err_cnt_cleared", 32'(err_cnt), 0);

        // Reset pulse mid-HOLD of the clean sweep
        lat = 0;
        while (vec_idx != 3'd2 && lat < 100) begin
            @(negedge sys_clk);
            lat++;
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_led", 32'(led), 0);
        check("mrst_vec", 32'(vec_idx), 0);
        check("mrst_ports", 32'({port_a, port_b, port_c}), 0);
        check("mrst_err", 32'({err, err_cnt}), 0);
        repeat (2) @(negedge sys_clk);
        check("mrst_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
